// File: rtl/seqdet_arb.sv
// Round-robin front end for a shared bit-serial Mealy sequence detector.
// Grants one of two word requesters, serializes the word MSB-first into the detector, and reports the hit count.
module seqdet_arb #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             det_clr,
  output logic             det_din,
  input  logic             det_dout,
  output logic             res_valid,
  output logic             res_id,
  output logic [CW-1:0]    res_count,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    SHIFT  = 2'd2,
    REPORT = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]    hit_cnt_q, hit_cnt_d;
  logic             id_q, id_d;
  logic             last_grant_q, last_grant_d;
  logic             res_id_q, res_id_d;
  logic [CW-1:0]    res_count_q, res_count_d;

  logic             grant_vld_s;
  logic             grant_id_s;

  // Arbitration: a tie goes to the requester that did not win last time
  always_comb begin
    grant_vld_s = 1'b0;
    grant_id_s  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_vld_s = 1'b1;
      grant_id_s  = ~last_grant_q;
    end else if (req0_valid) begin
      grant_vld_s = 1'b1;
      grant_id_s  = 1'b0;
    end else if (req1_valid) begin
      grant_vld_s = 1'b1;
      grant_id_s  = 1'b1;
    end else begin
      grant_vld_s = 1'b0;
      grant_id_s  = 1'b0;
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q      <= IDLE;
      shreg_q      <= {WIDTH{1'b0}};
      bit_cnt_q    <= {CW{1'b0}};
      hit_cnt_q    <= {CW{1'b0}};
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      res_id_q     <= 1'b0;
      res_count_q  <= {CW{1'b0}};
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      hit_cnt_q    <= hit_cnt_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      res_id_q     <= res_id_d;
      res_count_q  <= res_count_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    hit_cnt_d    = hit_cnt_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    res_id_d     = res_id_q;
    res_count_d  = res_count_q;
    case (state_q)
      IDLE: begin
        if (grant_vld_s) begin
          shreg_d   = grant_id_s ? req1_data : req0_data;
          id_d      = grant_id_s;
          hit_cnt_d = {CW{1'b0}};
          state_d   = CLEAR;
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        bit_cnt_d = {CW{1'b0}};
        state_d   = SHIFT;
      end
      SHIFT: begin
        if (det_dout) begin
          hit_cnt_d = hit_cnt_q + CW'(1);
        end else begin
          hit_cnt_d = hit_cnt_q;
        end
        shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + CW'(1);
        // The result registers are loaded here so they are already valid during REPORT
        if (bit_cnt_q == CW'(WIDTH - 1)) begin
          res_id_d    = id_q;
          res_count_d = hit_cnt_d;
          state_d     = REPORT;
        end else begin
          state_d = SHIFT;
        end
      end
      REPORT: begin
        last_grant_d = id_q;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode; while clr is held low every output shows its reset value
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    det_clr    = 1'b0;
    det_din    = 1'b0;
    res_valid  = 1'b0;
    busy       = 1'b0;
    res_id     = 1'b0;
    res_count  = {CW{1'b0}};
    if (!clr) begin
      det_clr = 1'b1;
    end else begin
      res_id    = res_id_q;
      res_count = res_count_q;
      case (state_q)
        IDLE: begin
          req0_ready = grant_vld_s & ~grant_id_s;
          req1_ready = grant_vld_s & grant_id_s;
        end
        CLEAR: begin
          busy    = 1'b1;
          det_clr = 1'b1;
        end
        SHIFT: begin
          busy    = 1'b1;
          det_din = shreg_q[WIDTH-1];
        end
        REPORT: begin
          busy      = 1'b1;
          res_valid = 1'b1;
        end
        default: begin
          busy = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seqdet_arb.sv
// Directed bench for seqdet_arb with a stub detector whose hit count equals the word popcount.
module tb_seqdet_arb;

  logic       clk;
  logic       clr;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       det_clr, det_din, det_dout;
  logic       res_valid, res_id;
  logic [3:0] res_count;
  logic       busy;

  logic       q0_valid, q1_valid;
  logic [3:0] q0_data, q1_data;
  logic       q0_ready, q1_ready;
  logic       d4_clr, d4_din, d4_dout;
  logic       r4_valid, r4_id;
  logic [2:0] r4_count;
  logic       busy4;

  int checks   = 0;
  int failures = 0;
  int viol     = 0;
  int res_ids[$];
  int res_cnts[$];
  int res_cyc[$];

  assign det_dout = det_din & ~det_clr;
  assign d4_dout  = d4_din & ~d4_clr;

  seqdet_arb #(.WIDTH(8)) dut (
    .clk(clk), .clr(clr),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .det_clr(det_clr), .det_din(det_din), .det_dout(det_dout),
    .res_valid(res_valid), .res_id(res_id), .res_count(res_count), .busy(busy)
  );

  seqdet_arb #(.WIDTH(4)) dut4 (
    .clk(clk), .clr(clr),
    .req0_valid(q0_valid), .req0_data(q0_data), .req0_ready(q0_ready),
    .req1_valid(q1_valid), .req1_data(q1_data), .req1_ready(q1_ready),
    .det_clr(d4_clr), .det_din(d4_din), .det_dout(d4_dout),
    .res_valid(r4_valid), .res_id(r4_id), .res_count(r4_count), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b0;
    req0_valid = 1'b1;
    req0_data  = 8'hAA;
    @(negedge clk);
    #1;
    check_eq("rst_det_clr", det_clr, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_res_valid", res_valid, 0);
    check_eq("rst_res_id", res_id, 0);
    check_eq("rst_res_count", res_count, 0);
    check_eq("rst_ready0", req0_ready, 0);
    req0_valid = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    #1;
    check_eq("post_rst_det_clr", det_clr, 0);
  endtask

  task automatic send_word(input logic id, input logic [7:0] data, input int exp_cnt);
    @(negedge clk);
    if (id) begin
      req1_valid = 1'b1;
      req1_data  = data;
    end else begin
      req0_valid = 1'b1;
      req0_data  = data;
    end
    #1;
    check_eq("accept_ready", id ? req1_ready : req0_ready, 1);
    check_eq("accept_busy", busy, 0);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    check_eq("clear_det_clr", det_clr, 1);
    check_eq("clear_busy", busy, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      check_eq($sformatf("din_bit%0d", i), det_din, data[7-i]);
    end
    @(negedge clk);
    #1;
    check_eq("report_valid", res_valid, 1);
    check_eq("report_id", res_id, id);
    check_eq("report_count", res_count, exp_cnt);
    @(negedge clk);
    #1;
    check_eq("after_valid", res_valid, 0);
    check_eq("after_busy", busy, 0);
    check_eq("held_count", res_count, exp_cnt);
  endtask

  task automatic run_arb(input logic v0, input logic v1, input int ncyc, input bit drop);
    logic acc0, acc1;
    acc0 = 1'b0;
    acc1 = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (c == 0) begin
        req0_valid = v0;
        req1_valid = v1;
      end
      if (drop && acc0) req0_valid = 1'b0;
      if (drop && acc1) req1_valid = 1'b0;
      #1;
      acc0 = req0_valid & req0_ready;
      acc1 = req1_valid & req1_ready;
      if ((req0_ready || req1_ready) && busy) viol++;
      if (res_valid) begin
        res_ids.push_back(int'(res_id));
        res_cnts.push_back(int'(res_count));
        res_cyc.push_back(c);
      end
    end
  endtask

  initial begin
    int seen;
    clr = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = 8'h00; req1_data = 8'h00;
    q0_valid = 1'b0; q1_valid = 1'b0;
    q0_data = 4'h0; q1_data = 4'h0;

    do_reset();

    // Reset while the fourth bit of a word is on det_din
    @(negedge clk);
    req0_valid = 1'b1;
    req0_data  = 8'hFF;
    #1;
    check_eq("mid_ready", req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    clr = 1'b0;
    #1;
    check_eq("mid_det_clr", det_clr, 1);
    check_eq("mid_res_valid", res_valid, 0);
    @(negedge clk);
    #1;
    check_eq("mid_busy", busy, 0);
    check_eq("mid_det_clr2", det_clr, 1);
    clr = 1'b1;
    #1;
    check_eq("mid_idle_det_clr", det_clr, 0);
    check_eq("mid_idle_busy", busy, 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      if (res_valid || busy) seen++;
    end
    check_eq("mid_no_result", seen, 0);

    send_word(1'b0, 8'hB5, 5);
    send_word(1'b0, 8'h00, 0);
    send_word(1'b0, 8'hFF, 8);

    // Tie right after reset: req0 first, then req1
    do_reset();
    req0_data = 8'h0F;
    req1_data = 8'hF0;
    res_ids.delete(); res_cnts.delete(); res_cyc.delete();
    run_arb(1'b1, 1'b1, 30, 1'b1);
    check_eq("tie_nres", res_ids.size(), 2);
    if (res_ids.size() == 2) begin
      check_eq("tie_id0", res_ids[0], 0);
      check_eq("tie_cnt0", res_cnts[0], 4);
      check_eq("tie_lat0", res_cyc[0], 10);
      check_eq("tie_id1", res_ids[1], 1);
      check_eq("tie_cnt1", res_cnts[1], 4);
      check_eq("tie_gap", res_cyc[1] - res_cyc[0], 11);
    end

    // Sustained contention for six words
    req0_data = 8'h81;
    req1_data = 8'h7E;
    res_ids.delete(); res_cnts.delete(); res_cyc.delete();
    viol = 0;
    run_arb(1'b1, 1'b1, 66, 1'b0);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check_eq("cont_nres", res_ids.size(), 6);
    check_eq("cont_ready_while_busy", viol, 0);
    for (int k = 0; k < res_ids.size(); k++) begin
      check_eq($sformatf("cont_id%0d", k), res_ids[k], k % 2);
      check_eq($sformatf("cont_cnt%0d", k), res_cnts[k], (k % 2 == 1) ? 6 : 2);
      check_eq($sformatf("cont_cyc%0d", k), res_cyc[k], 10 + 11 * k);
    end

    // Four-bit instance, all-ones word
    @(negedge clk);
    @(negedge clk);
    q0_valid = 1'b1;
    q0_data  = 4'hF;
    #1;
    check_eq("w4_ready", q0_ready, 1);
    @(negedge clk);
    q0_valid = 1'b0;
    #1;
    check_eq("w4_det_clr", d4_clr, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check_eq($sformatf("w4_din%0d", i), d4_din, 1);
    end
    @(negedge clk);
    #1;
    check_eq("w4_res_valid", r4_valid, 1);
    check_eq("w4_res_id", r4_id, 0);
    check_eq("w4_res_count", r4_count, 4);
    @(negedge clk);
    #1;
    check_eq("w4_idle", busy4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
